xbar_cfg_loader: RTL and testbench

- Configuration controller for the LUT-tile input crossbar.
- Accepts the crossbar's packed mux-select vector as a stream of 32-bit words into a shadow register.
- Range-checks every select field, then commits the shadow to the active select bus on an apply strobe.
- Sits between the tile's config bus and the crossbar's io_mux_configs input, so the fabric only ever sees a complete, legal configuration.

---
 rtl/xbar_cfg_pkg.sv | 22 ++
 rtl/xbar_cfg_loader.sv | 146 ++++++++++++++
 tb/tb_xbar_cfg_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_cfg_pkg.sv
// Shared constants and state type for the crossbar configuration loader.
package xbar_cfg_pkg;

  localparam int unsigned NUM_IN    = 20;
  localparam int unsigned NUM_OUT   = 25;
  localparam int unsigned SEL_W     = 5;
  localparam int unsigned CFG_W     = NUM_OUT * SEL_W;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;

  // Word counter width and the number of meaningful bits in the final word.
  localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned LAST_W    = CFG_W - (NUM_WORDS - 1) * WORD_W;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StArmed
  } state_e;

endpackage

// File: rtl/xbar_cfg_loader.sv
// Streams a packed mux-select frame into a shadow register, range-checks each
// field, and commits the shadow to the crossbar select bus on an apply strobe.
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] io_cfg_word,
  input  logic              io_cfg_valid,
  output logic              io_cfg_ready,
  input  logic              io_apply,
  input  logic              io_abort,
  output logic [CFG_W-1:0]  io_mux_configs,
  output logic              io_busy,
  output logic              io_armed,
  output logic              io_done,
  output logic              io_err,
  output logic [SEL_W-1:0]  io_err_index
);

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   mux_q, mux_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEL_W-1:0]   chk_idx_q, chk_idx_d;
  logic [SEL_W-1:0]   err_idx_q, err_idx_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               xfer;
  logic               word_last;
  logic [SEL_W-1:0]   field;
  logic               field_bad;
  logic               field_last;
  logic               abort_act;
  logic               commit;

  assign xfer       = io_cfg_valid & io_cfg_ready;
  assign word_last  = (count_q == CNT_W'(NUM_WORDS - 1));
  // Single comparator on a shadow-indexed mux; one field per CHECK cycle.
  assign field      = shadow_q[chk_idx_q*SEL_W +: SEL_W];
  assign field_bad  = (field >= SEL_W'(NUM_IN));
  assign field_last = (chk_idx_q == SEL_W'(NUM_OUT - 1));
  assign abort_act  = io_abort & (state_q != StIdle);
  assign commit     = (state_q == StArmed) & io_apply & ~io_abort;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other event outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer) state_d = StLoad;
      StLoad: begin
        if (io_abort)               state_d = StIdle;
        else if (xfer && word_last) state_d = StCheck;
      end
      StCheck: begin
        if (io_abort || field_bad) state_d = StIdle;
        else if (field_last)       state_d = StArmed;
      end
      StArmed: if (io_abort || io_apply) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    io_cfg_ready = ((state_q == StIdle) || (state_q == StLoad)) && !io_abort;
    io_busy      = (state_q != StIdle);
    io_armed     = (state_q == StArmed);
  end

  // Datapath next-state: shadow fill, word/field counters, error capture, commit.
  always_comb begin
    shadow_d  = shadow_q;
    mux_d     = mux_q;
    count_d   = count_q;
    chk_idx_d = chk_idx_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    done_d    = commit;

    if (xfer) begin
      for (int unsigned k = 0; k < NUM_WORDS - 1; k++) begin
        if (count_q == CNT_W'(k)) shadow_d[k*WORD_W +: WORD_W] = io_cfg_word;
      end
      // Bits of the final word beyond the select vector are dropped.
      if (word_last) shadow_d[CFG_W-1 -: LAST_W] = io_cfg_word[LAST_W-1:0];
      count_d   = word_last ? '0 : count_q + 1'b1;
      chk_idx_d = '0;
      if (state_q == StIdle) begin
        err_d     = 1'b0;
        err_idx_d = '0;
      end
    end

    // Count is kept at zero whenever the FSM is in IDLE.
    if (abort_act) count_d = '0;

    if ((state_q == StCheck) && !io_abort) begin
      if (field_bad) begin
        err_d     = 1'b1;
        err_idx_d = chk_idx_q;
      end else begin
        chk_idx_d = chk_idx_q + 1'b1;
      end
    end

    if (commit) mux_d = shadow_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= '0;
      mux_q     <= '0;
      count_q   <= '0;
      chk_idx_q <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      mux_q     <= mux_d;
      count_q   <= count_d;
      chk_idx_q <= chk_idx_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      done_q    <= done_d;
    end
  end

  assign io_mux_configs = mux_q;
  assign io_done        = done_q;
  assign io_err         = err_q;
  assign io_err_index   = err_idx_q;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader: drives and samples on the falling edge.
module tb_xbar_cfg_loader;
  import xbar_cfg_pkg::*;

  logic              clk;
  logic              reset;
  logic [WORD_W-1:0] io_cfg_word;
  logic              io_cfg_valid;
  logic              io_cfg_ready;
  logic              io_apply;
  logic              io_abort;
  logic [CFG_W-1:0]  io_mux_configs;
  logic              io_busy;
  logic              io_armed;
  logic              io_done;
  logic              io_err;
  logic [SEL_W-1:0]  io_err_index;

  int checks;
  int failures;

  logic [CFG_W-1:0] fa, fb, fc, fd, fe;
  logic [NUM_WORDS*WORD_W-1:0] pad;

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .io_cfg_word    (io_cfg_word),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_apply       (io_apply),
    .io_abort       (io_abort),
    .io_mux_configs (io_mux_configs),
    .io_busy        (io_busy),
    .io_armed       (io_armed),
    .io_done        (io_done),
    .io_err         (io_err),
    .io_err_index   (io_err_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field i = (mul*i + add) mod NUM_IN, always legal.
  function automatic logic [CFG_W-1:0] make_frame(input int unsigned mul, input int unsigned add);
    logic [CFG_W-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) f[i*SEL_W +: SEL_W] = SEL_W'((mul * i + add) % NUM_IN);
    return f;
  endfunction

  // Starts and ends on a falling edge; the transfer happens at the rising edge between.
  task automatic send_word(input logic [WORD_W-1:0] w, input int unsigned gap);
    io_cfg_word  = w;
    io_cfg_valid = 1'b1;
    @(negedge clk);
    io_cfg_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Final word carries set pad bits above CFG_W, which must be ignored. Last gap is 0.
  task automatic send_frame(input logic [CFG_W-1:0] f, input int unsigned gap_seed);
    logic [NUM_WORDS*WORD_W-1:0] p;
    p = {{(NUM_WORDS*WORD_W-CFG_W){1'b1}}, f};
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      send_word(p[k*WORD_W +: WORD_W], (k == NUM_WORDS - 1) ? 0 : ((gap_seed >> (2*k)) & 3));
    end
  endtask

  task automatic wait_armed(input string tag);
    int n;
    n = 0;
    while (!io_armed && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, io_armed, 1);
  endtask

  task automatic do_apply();
    io_apply = 1'b1;
    @(negedge clk);
    io_apply = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    io_cfg_word = '0;
    io_cfg_valid = 1'b0;
    io_apply = 1'b0;
    io_abort = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_hold_mux", io_mux_configs, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mux", io_mux_configs, 0);
    check("rst_ready", io_cfg_ready, 1);
    check("rst_busy", io_busy, 0);
    check("rst_err", io_err, 0);
    check("rst_done", io_done, 0);
    check("rst_armed", io_armed, 0);
    check("rst_err_idx", io_err_index, 0);

    // Legal frame, back-to-back; ARMED exactly 26 cycles after the last word
    fa = make_frame(1, 0);
    send_frame(fa, 0);
    check("legal_busy", io_busy, 1);
    repeat (24) @(negedge clk);
    check("legal_not_armed_c25", io_armed, 0);
    check("legal_busy_c25", io_busy, 1);
    @(negedge clk);
    check("legal_armed_c26", io_armed, 1);
    check("legal_mux_pre_apply", io_mux_configs, 0);
    do_apply();
    check("legal_done", io_done, 1);
    check("legal_mux", io_mux_configs, fa);
    check("legal_field21", io_mux_configs[21*SEL_W +: SEL_W], 1);
    check("legal_field24", io_mux_configs[24*SEL_W +: SEL_W], 4);
    check("legal_idle", io_busy, 0);
    @(negedge clk);
    check("legal_done_pulse", io_done, 0);
    check("legal_mux_hold", io_mux_configs, fa);

    // Illegal field 7 = 21
    fb = '0;
    fb[7*SEL_W +: SEL_W] = 5'd21;
    send_frame(fb, 0);
    repeat (7) @(negedge clk);
    check("ill_no_err_yet", io_err, 0);
    check("ill_busy", io_busy, 1);
    @(negedge clk);
    check("ill_err", io_err, 1);
    check("ill_err_idx", io_err_index, 7);
    check("ill_idle", io_busy, 0);
    check("ill_mux_kept", io_mux_configs, fa);
    // Apply outside ARMED is ignored
    do_apply();
    check("ill_apply_done", io_done, 0);
    check("ill_apply_mux", io_mux_configs, fa);
    check("ill_err_sticky", io_err, 1);
    send_word(32'h0, 0);
    check("ill_err_clear", io_err, 0);
    check("ill_idx_clear", io_err_index, 0);
    io_abort = 1'b1;
    @(negedge clk);
    io_abort = 1'b0;
    check("ill_abort_idle", io_busy, 0);

    // Abort after word 2 with gaps; abort beats a pending transfer
    fc = make_frame(3, 1);
    pad = {{(NUM_WORDS*WORD_W-CFG_W){1'b1}}, fc};
    send_word(pad[0 +: WORD_W], 2);
    send_word(pad[WORD_W +: WORD_W], 0);
    send_word(pad[2*WORD_W +: WORD_W], 3);
    io_abort = 1'b1;
    io_cfg_valid = 1'b1;
    io_cfg_word = pad[3*WORD_W +: WORD_W];
    #1;
    check("abort_ready_low", io_cfg_ready, 0);
    check("abort_busy", io_busy, 1);
    @(negedge clk);
    io_abort = 1'b0;
    io_cfg_valid = 1'b0;
    check("abort_idle", io_busy, 0);
    check("abort_mux_kept", io_mux_configs, fa);
    send_frame(fc, 32'b11_01_10);
    wait_armed("abort_reload_armed");
    do_apply();
    check("abort_reload_done", io_done, 1);
    check("abort_reload_mux", io_mux_configs, fc);

    // Apply/abort collision in ARMED
    fd = make_frame(7, 5);
    send_frame(fd, 0);
    wait_armed("coll_armed");
    io_apply = 1'b1;
    io_abort = 1'b1;
    @(negedge clk);
    io_apply = 1'b0;
    io_abort = 1'b0;
    check("coll_done", io_done, 0);
    check("coll_idle", io_busy, 0);
    check("coll_armed", io_armed, 0);
    check("coll_mux", io_mux_configs, fc);

    // Reset at CHECK index 10
    fe = make_frame(1, 3);
    send_frame(fe, 0);
    repeat (10) @(negedge clk);
    check("rchk_busy", io_busy, 1);
    reset = 1'b0;
    #1;
    check("rchk_mux", io_mux_configs, 0);
    check("rchk_busy0", io_busy, 0);
    check("rchk_err", io_err, 0);
    check("rchk_done", io_done, 0);
    check("rchk_armed", io_armed, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame(fe, 32'b01_00_01);
    wait_armed("rchk_fresh_armed");
    do_apply();
    check("rchk_fresh_done", io_done, 1);
    check("rchk_fresh_mux", io_mux_configs, fe);
    @(negedge clk);
    check("rchk_fresh_done_pulse", io_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
